// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter that multiplexes NREQ requesters onto one cache controller port.
// One transaction in flight; registered outputs; bounded wait with a timeout response.
module cache_req_arbiter #(
  parameter int NREQ      = 2,
  parameter int PA_WIDTH  = 32,
  parameter int WRD_WIDTH = 32,
  parameter int TIMEOUT   = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_rd_en,
  input  logic [NREQ-1:0]           req_wr_en,
  input  logic [NREQ*PA_WIDTH-1:0]  req_addr,
  input  logic [NREQ*WRD_WIDTH-1:0] req_data_wr,
  output logic [NREQ-1:0]           gnt,
  output logic [NREQ-1:0]           done,
  output logic [WRD_WIDTH-1:0]      rsp_word,
  output logic                      rsp_hit,
  output logic                      rsp_err,
  output logic                      c_rd_en,
  output logic                      c_wr_en,
  output logic [PA_WIDTH-1:0]       c_addr,
  output logic [WRD_WIDTH-1:0]      c_data_wr,
  input  logic [WRD_WIDTH-1:0]      c_word_out,
  input  logic                      c_hit,
  input  logic                      c_done
);
  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          rr_q, rr_d;
  logic [IW-1:0]          sel_q, sel_d;
  logic                   is_wr_q, is_wr_d;
  logic [7:0]             wcnt_q, wcnt_d;
  logic [NREQ-1:0]        gnt_q, gnt_d;
  logic [NREQ-1:0]        done_q, done_d;
  logic [WRD_WIDTH-1:0]   rsp_word_q, rsp_word_d;
  logic                   rsp_hit_q, rsp_hit_d;
  logic                   rsp_err_q, rsp_err_d;
  logic                   c_rd_en_q, c_rd_en_d;
  logic                   c_wr_en_q, c_wr_en_d;
  logic [PA_WIDTH-1:0]    c_addr_q, c_addr_d;
  logic [WRD_WIDTH-1:0]   c_data_wr_q, c_data_wr_d;

  logic [NREQ-1:0]        pend;
  logic                   found;
  logic [IW-1:0]          pick;

  assign pend = req_rd_en | req_wr_en;

  // Rotating priority search starting at rr_q.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NREQ; k++) begin
      int cand;
      cand = int'(rr_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!found && pend[IW'(cand)]) begin
        found = 1'b1;
        pick  = IW'(cand);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    sel_d       = sel_q;
    is_wr_d     = is_wr_q;
    wcnt_d      = wcnt_q;
    gnt_d       = '0;
    done_d      = '0;
    rsp_word_d  = rsp_word_q;
    rsp_hit_d   = rsp_hit_q;
    rsp_err_d   = rsp_err_q;
    c_rd_en_d   = 1'b0;
    c_wr_en_d   = 1'b0;
    c_addr_d    = c_addr_q;
    c_data_wr_d = c_data_wr_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          sel_d       = pick;
          is_wr_d     = req_wr_en[pick];
          c_addr_d    = req_addr[pick*PA_WIDTH +: PA_WIDTH];
          c_data_wr_d = req_data_wr[pick*WRD_WIDTH +: WRD_WIDTH];
          gnt_d[pick] = 1'b1;
          c_wr_en_d   = req_wr_en[pick];
          c_rd_en_d   = !req_wr_en[pick];
          wcnt_d      = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE, WAIT: begin
        if (c_done) begin
          rsp_word_d    = is_wr_q ? '0 : c_word_out;
          rsp_hit_d     = c_hit;
          rsp_err_d     = 1'b0;
          done_d[sel_q] = 1'b1;
          state_d       = RESP;
        end else if (wcnt_q == 8'(TIMEOUT - 1)) begin
          rsp_word_d    = '0;
          rsp_hit_d     = 1'b0;
          rsp_err_d     = 1'b1;
          done_d[sel_q] = 1'b1;
          state_d       = RESP;
        end else begin
          wcnt_d  = wcnt_q + 8'd1;
          state_d = WAIT;
        end
      end
      RESP: begin
        rr_d    = (sel_q == IW'(NREQ - 1)) ? '0 : sel_q + IW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      sel_q       <= '0;
      is_wr_q     <= 1'b0;
      wcnt_q      <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      rsp_word_q  <= '0;
      rsp_hit_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      c_rd_en_q   <= 1'b0;
      c_wr_en_q   <= 1'b0;
      c_addr_q    <= '0;
      c_data_wr_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      sel_q       <= sel_d;
      is_wr_q     <= is_wr_d;
      wcnt_q      <= wcnt_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      rsp_word_q  <= rsp_word_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_err_q   <= rsp_err_d;
      c_rd_en_q   <= c_rd_en_d;
      c_wr_en_q   <= c_wr_en_d;
      c_addr_q    <= c_addr_d;
      c_data_wr_q <= c_data_wr_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign rsp_word  = rsp_word_q;
  assign rsp_hit   = rsp_hit_q;
  assign rsp_err   = rsp_err_q;
  assign c_rd_en   = c_rd_en_q;
  assign c_wr_en   = c_wr_en_q;
  assign c_addr    = c_addr_q;
  assign c_data_wr = c_data_wr_q;

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Directed bench for cache_req_arbiter: two ports, TIMEOUT=8, hand-computed expectations.
module tb_cache_req_arbiter;
  localparam int NREQ = 2;
  localparam int PAW  = 32;
  localparam int WW   = 32;
  localparam int TO   = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_rd_en, req_wr_en;
  logic [NREQ*PAW-1:0] req_addr;
  logic [NREQ*WW-1:0]  req_data_wr;
  logic [NREQ-1:0]   gnt, done;
  logic [WW-1:0]     rsp_word;
  logic              rsp_hit, rsp_err;
  logic              c_rd_en, c_wr_en;
  logic [PAW-1:0]    c_addr;
  logic [WW-1:0]     c_data_wr;
  logic [WW-1:0]     c_word_out;
  logic              c_hit, c_done;

  int n_cmp  = 0;
  int n_fail = 0;

  cache_req_arbiter #(.NREQ(NREQ), .PA_WIDTH(PAW), .WRD_WIDTH(WW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_rd_en(req_rd_en), .req_wr_en(req_wr_en),
    .req_addr(req_addr), .req_data_wr(req_data_wr),
    .gnt(gnt), .done(done),
    .rsp_word(rsp_word), .rsp_hit(rsp_hit), .rsp_err(rsp_err),
    .c_rd_en(c_rd_en), .c_wr_en(c_wr_en),
    .c_addr(c_addr), .c_data_wr(c_data_wr),
    .c_word_out(c_word_out), .c_hit(c_hit), .c_done(c_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({gnt, done, c_rd_en, c_wr_en, rsp_hit, rsp_err} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 0", {gnt, done, c_rd_en, c_wr_en, rsp_hit, rsp_err});
    end
    n_cmp++;
    if ({c_addr, c_data_wr, rsp_word} !== 96'b0) begin
      n_fail++;
      $display("FAIL reset_data: got %h required 0", {c_addr, c_data_wr, rsp_word});
    end
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    req_rd_en = 2'b01;
    req_addr  = {32'h0, 32'h0000_1040};
    tick();
    n_cmp++;
    if (gnt !== 2'b01 || c_rd_en !== 1'b1 || c_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_issue: gnt=%b rd=%b wr=%b required 01 1 0", gnt, c_rd_en, c_wr_en);
    end
    n_cmp++;
    if (c_addr !== 32'h0000_1040) begin
      n_fail++;
      $display("FAIL rd_addr: got %h required 00001040", c_addr);
    end
    req_rd_en = 2'b00;
    tick();
    n_cmp++;
    if (gnt !== 2'b00 || c_rd_en !== 1'b0 || done !== 2'b00) begin
      n_fail++;
      $display("FAIL rd_one_cycle: gnt=%b rd=%b done=%b required 00 0 00", gnt, c_rd_en, done);
    end
    c_done = 1'b1; c_hit = 1'b1; c_word_out = 32'hDEAD_BEEF;
    tick();
    c_done = 1'b0; c_hit = 1'b0; c_word_out = 32'h0;
    n_cmp++;
    if (done !== 2'b01 || rsp_word !== 32'hDEAD_BEEF || rsp_hit !== 1'b1 || rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_done: done=%b word=%h hit=%b err=%b required 01 deadbeef 1 0",
               done, rsp_word, rsp_hit, rsp_err);
    end
    n_cmp++;
    if (c_addr !== 32'h0000_1040) begin
      n_fail++;
      $display("FAIL rd_addr_hold: got %h required 00001040", c_addr);
    end
    tick();
    n_cmp++;
    if (done !== 2'b00) begin
      n_fail++;
      $display("FAIL rd_done_pulse: got %b required 00", done);
    end
  endtask

  task automatic test_alternation();
    logic [1:0]  exp_g;
    logic [31:0] exp_a, exp_w;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_rd_en = 2'b11;
    req_addr  = {32'h0000_2200, 32'h0000_1100};
    for (int i = 0; i < 3; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_a = (i % 2 == 0) ? 32'h0000_1100 : 32'h0000_2200;
      exp_w = 32'hA000_0000 + i;
      tick();
      n_cmp++;
      if (gnt !== exp_g || c_addr !== exp_a) begin
        n_fail++;
        $display("FAIL alt_gnt%0d: gnt=%b addr=%h required %b %h", i, gnt, c_addr, exp_g, exp_a);
      end
      tick();
      c_done = 1'b1; c_hit = 1'b0; c_word_out = exp_w;
      tick();
      c_done = 1'b0;
      n_cmp++;
      if (done !== exp_g || rsp_word !== exp_w || rsp_hit !== 1'b0) begin
        n_fail++;
        $display("FAIL alt_done%0d: done=%b word=%h hit=%b required %b %h 0",
                 i, done, rsp_word, rsp_hit, exp_g, exp_w);
      end
      if (i == 2) req_rd_en = 2'b00;
      tick();
    end
  endtask

  task automatic test_write();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_rd_en   = 2'b10;
    req_wr_en   = 2'b10;
    req_addr    = {32'h0000_3000, 32'h0};
    req_data_wr = {32'h1234_5678, 32'h0};
    tick();
    n_cmp++;
    if (gnt !== 2'b10 || c_wr_en !== 1'b1 || c_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_issue: gnt=%b wr=%b rd=%b required 10 1 0", gnt, c_wr_en, c_rd_en);
    end
    n_cmp++;
    if (c_data_wr !== 32'h1234_5678 || c_addr !== 32'h0000_3000) begin
      n_fail++;
      $display("FAIL wr_data: data=%h addr=%h required 12345678 00003000", c_data_wr, c_addr);
    end
    req_rd_en = 2'b00; req_wr_en = 2'b00;
    tick();
    c_done = 1'b1; c_hit = 1'b1; c_word_out = 32'hFFFF_FFFF;
    tick();
    c_done = 1'b0; c_word_out = 32'h0; c_hit = 1'b0;
    n_cmp++;
    if (done !== 2'b10 || rsp_word !== 32'h0 || rsp_hit !== 1'b1 || c_data_wr !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL wr_done: done=%b word=%h hit=%b data=%h required 10 0 1 12345678",
               done, rsp_word, rsp_hit, c_data_wr);
    end
    tick();
  endtask

  task automatic test_timeout();
    // rr pointer is 0 here (port 1 served last); only port 0 requests.
    req_rd_en = 2'b01;
    req_addr  = {32'h0, 32'h0000_4000};
    tick();
    n_cmp++;
    if (gnt !== 2'b01) begin
      n_fail++;
      $display("FAIL to_gnt: got %b required 01", gnt);
    end
    req_rd_en = 2'b00;
    c_hit = 1'b1; c_word_out = 32'h5555_AAAA;
    for (int k = 1; k < TO; k++) begin
      tick();
      n_cmp++;
      if (done !== 2'b00) begin
        n_fail++;
        $display("FAIL to_early%0d: done=%b required 00", k, done);
      end
    end
    tick();
    n_cmp++;
    if (done !== 2'b01 || rsp_err !== 1'b1 || rsp_hit !== 1'b0 || rsp_word !== 32'h0) begin
      n_fail++;
      $display("FAIL to_done: done=%b err=%b hit=%b word=%h required 01 1 0 0",
               done, rsp_err, rsp_hit, rsp_word);
    end
    c_hit = 1'b0; c_word_out = 32'h0;
    tick();
    req_rd_en = 2'b10;
    req_addr  = {32'h0000_5000, 32'h0};
    tick();
    n_cmp++;
    if (gnt !== 2'b10 || c_addr !== 32'h0000_5000) begin
      n_fail++;
      $display("FAIL to_next_gnt: gnt=%b addr=%h required 10 00005000", gnt, c_addr);
    end
    req_rd_en = 2'b00;
    tick();
    c_done = 1'b1; c_word_out = 32'h0BAD_F00D;
    tick();
    c_done = 1'b0;
    n_cmp++;
    if (done !== 2'b10 || rsp_err !== 1'b0 || rsp_word !== 32'h0BAD_F00D) begin
      n_fail++;
      $display("FAIL to_next_done: done=%b err=%b word=%h required 10 0 0badf00d",
               done, rsp_err, rsp_word);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    req_rd_en = 2'b10;
    req_addr  = {32'h0000_6000, 32'h0000_7000};
    tick();
    n_cmp++;
    if (gnt !== 2'b10) begin
      n_fail++;
      $display("FAIL rm_gnt: got %b required 10", gnt);
    end
    req_rd_en = 2'b00;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({gnt, done, c_rd_en, c_wr_en, rsp_hit, rsp_err} !== 8'b0 || {c_addr, rsp_word} !== 64'b0) begin
      n_fail++;
      $display("FAIL rm_outputs: ctrl=%b addr=%h word=%h required 0",
               {gnt, done, c_rd_en, c_wr_en, rsp_hit, rsp_err}, c_addr, rsp_word);
    end
    c_done = 1'b1; c_word_out = 32'h1111_1111;
    tick();
    c_done = 1'b0;
    n_cmp++;
    if (done !== 2'b00 || rsp_word !== 32'h0) begin
      n_fail++;
      $display("FAIL rm_no_done: done=%b word=%h required 00 0", done, rsp_word);
    end
    req_rd_en = 2'b11;
    tick();
    n_cmp++;
    if (gnt !== 2'b01 || c_addr !== 32'h0000_7000) begin
      n_fail++;
      $display("FAIL rm_port0_first: gnt=%b addr=%h required 01 00007000", gnt, c_addr);
    end
    req_rd_en = 2'b00;
    tick();
    c_done = 1'b1; c_word_out = 32'h2222_2222;
    tick();
    c_done = 1'b0;
    n_cmp++;
    if (done !== 2'b01 || rsp_word !== 32'h2222_2222) begin
      n_fail++;
      $display("FAIL rm_after_done: done=%b word=%h required 01 22222222", done, rsp_word);
    end
    tick();
  endtask

  task automatic test_spurious_done();
    tick();
    c_done = 1'b1; c_hit = 1'b1; c_word_out = 32'h3333_3333;
    tick();
    c_done = 1'b0; c_hit = 1'b0;
    n_cmp++;
    if (done !== 2'b00 || gnt !== 2'b00 || c_rd_en !== 1'b0 || rsp_word !== 32'h2222_2222) begin
      n_fail++;
      $display("FAIL idle_cdone: done=%b gnt=%b rd=%b word=%h required 00 00 0 22222222",
               done, gnt, c_rd_en, rsp_word);
    end
    tick();
    n_cmp++;
    if (done !== 2'b00 || gnt !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_quiet: done=%b gnt=%b required 00 00", done, gnt);
    end
    req_rd_en = 2'b01;
    req_addr  = {32'h0, 32'h0000_8000};
    tick();
    req_rd_en = 2'b00;
    n_cmp++;
    if (gnt !== 2'b01 || c_rd_en !== 1'b1 || c_addr !== 32'h0000_8000) begin
      n_fail++;
      $display("FAIL idle_then_gnt: gnt=%b rd=%b addr=%h required 01 1 00008000", gnt, c_rd_en, c_addr);
    end
  endtask

  initial begin
    rst         = 1'b1;
    req_rd_en   = '0;
    req_wr_en   = '0;
    req_addr    = '0;
    req_data_wr = '0;
    c_word_out  = '0;
    c_hit       = 1'b0;
    c_done      = 1'b0;
    test_reset();
    test_single_read();
    test_alternation();
    test_write();
    test_timeout();
    test_reset_mid();
    test_spurious_done();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
